// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default link constants,
// common to the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int CLKS_PER_BIT_115200 = 434;
  localparam int UART_DATA_BITS      = 8;

endpackage

// File: rtl/uart_baud_timer.sv
// Clearable bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the wrap
// cycle with bit_tick so the owning FSM can advance on the same edge.
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  output logic bit_tick
);

  localparam int           W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign bit_tick = (count == LAST);

  // NOTE: reset is synchronous, so it is just the highest-priority branch of the clocked block.
  always_ff @(posedge CLK) begin
    if (!nRST || clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, LSB-first 8N1 / 8E1 / 8O1 framing,
// registered idle-high serial output and a one-cycle frame-done pulse.
module uart_tx
  import uart_pkg::*;
#(
  parameter int   CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter logic PARITY_EN    = 1'b0,
  parameter logic PARITY_ODD   = 1'b0
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        parity_bit;
  logic        bit_tick;

  // Holding the timer clear while idle makes acceptance restart the bit period.
  uart_baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (state == IDLE),
    .bit_tick(bit_tick)
  );

  // NOTE: every register here is a flop, so all assignments are non-blocking.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      tx_serial  <= 1'b1;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          if (tx_valid && tx_ready) begin
            shreg      <= tx_data;
            parity_bit <= (^tx_data) ^ PARITY_ODD;
            bit_idx    <= '0;
            tx_ready   <= 1'b0;
            tx_serial  <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            tx_serial <= shreg[0];
            state     <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
              if (PARITY_EN) begin
                tx_serial <= parity_bit;
                state     <= PARITY;
              end else begin
                tx_serial <= 1'b1;
                state     <= STOP;
              end
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shreg     <= shreg >> 1;
              tx_serial <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            tx_serial <= 1'b1;
            state     <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            tx_ready <= 1'b1;
            tx_done  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          tx_serial <= 1'b1;
          tx_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit: one 8N1, one 8E1 and one 8O1
// instance share clock, reset and data; each has its own tx_valid.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] tx_data;
  logic       valid_n, valid_e, valid_o;
  logic       ready_n, ready_e, ready_o;
  logic       ser_n, ser_e, ser_o;
  logic       done_n, done_e, done_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_n (
    .CLK(CLK), .nRST(nRST), .tx_valid(valid_n), .tx_data(tx_data),
    .tx_ready(ready_n), .tx_serial(ser_n), .tx_done(done_n));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_e (
    .CLK(CLK), .nRST(nRST), .tx_valid(valid_e), .tx_data(tx_data),
    .tx_ready(ready_e), .tx_serial(ser_e), .tx_done(done_e));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_o (
    .CLK(CLK), .nRST(nRST), .tx_valid(valid_o), .tx_data(tx_data),
    .tx_ready(ready_o), .tx_serial(ser_o), .tx_done(done_o));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_valid(input int sel, input logic v);
    case (sel)
      0:       valid_n = v;
      1:       valid_e = v;
      default: valid_o = v;
    endcase
  endtask

  function automatic logic ser_of(input int sel);
    case (sel)
      0:       return ser_n;
      1:       return ser_e;
      default: return ser_o;
    endcase
  endfunction

  function automatic logic ready_of(input int sel);
    case (sel)
      0:       return ready_n;
      1:       return ready_e;
      default: return ready_o;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_n;
      1:       return done_e;
      default: return done_o;
    endcase
  endfunction

  // Expected line level in frame cycle k (1-based, acceptance edge is cycle 0).
  function automatic logic exp_bit(input int k, input logic [7:0] d,
                                   input logic pen, input logic pbit);
    int slot;
    slot = (k - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (slot == 9 && pen) return pbit;
    return 1'b1;
  endfunction

  // Called in frame cycle 1; checks cycles 1..F and returns in cycle F+1.
  // A nonzero poke cycle offers 0x3C with a one-cycle tx_valid mid-frame.
  task automatic frame_body(input int sel, input logic [7:0] d, input logic pen,
                            input logic pbit, input int poke, input string tag);
    int f;
    f = (pen ? 11 : 10) * CPB;
    for (int k = 1; k <= f; k++) begin
      if (poke != 0 && k == poke) begin
        tx_data = 8'h3C;
        set_valid(sel, 1'b1);
      end
      if (poke != 0 && k == poke + 1) set_valid(sel, 1'b0);
      check($sformatf("%s serial c%0d", tag, k), 8'(ser_of(sel)), 8'(exp_bit(k, d, pen, pbit)));
      check($sformatf("%s ready c%0d", tag, k), 8'(ready_of(sel)), 8'h0);
      check($sformatf("%s done c%0d", tag, k), 8'(done_of(sel)), 8'h0);
      step();
    end
    check($sformatf("%s serial end", tag), 8'(ser_of(sel)), 8'h1);
    check($sformatf("%s ready end", tag), 8'(ready_of(sel)), 8'h1);
    check($sformatf("%s done end", tag), 8'(done_of(sel)), 8'h1);
  endtask

  task automatic accept(input int sel, input logic [7:0] d);
    tx_data = d;
    set_valid(sel, 1'b1);
    step();
  endtask

  initial begin
    nRST    = 1'b0;
    valid_n = 1'b1;
    valid_e = 1'b0;
    valid_o = 1'b0;
    tx_data = 8'hA5;

    // Reset held three cycles with tx_valid asserted.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst serial %0d", i), 8'(ser_n), 8'h1);
      check($sformatf("rst ready %0d", i), 8'(ready_n), 8'h1);
      check($sformatf("rst done %0d", i), 8'(done_n), 8'h0);
    end
    check("rst ready e", 8'(ready_e), 8'h1);
    check("rst serial o", 8'(ser_o), 8'h1);
    valid_n = 1'b0;
    nRST    = 1'b1;
    step();
    check("post-rst serial", 8'(ser_n), 8'h1);
    check("post-rst ready", 8'(ready_n), 8'h1);

    // 8N1, 0xA5.
    accept(0, 8'hA5);
    set_valid(0, 1'b0);
    frame_body(0, 8'hA5, 1'b0, 1'b0, 0, "n_a5");
    step();
    check("n_a5 done clears", 8'(done_n), 8'h0);

    // 8E1 and 8O1, 0x07 (three ones): even -> 1, odd -> 0.
    accept(1, 8'h07);
    set_valid(1, 1'b0);
    frame_body(1, 8'h07, 1'b1, 1'b1, 0, "e_07");
    step();
    accept(2, 8'h07);
    set_valid(2, 1'b0);
    frame_body(2, 8'h07, 1'b1, 1'b0, 0, "o_07");
    step();

    // Back-to-back with tx_valid held: 0x00 then 0xFF.
    accept(0, 8'h00);
    tx_data = 8'hFF;
    frame_body(0, 8'h00, 1'b0, 1'b0, 0, "b2b_00");
    step();
    set_valid(0, 1'b0);
    frame_body(0, 8'hFF, 1'b0, 1'b0, 0, "b2b_ff");
    step();
    check("b2b idle done", 8'(done_n), 8'h0);

    // Busy immunity: 0x3C offered during the 0xA5 frame is dropped.
    accept(0, 8'hA5);
    set_valid(0, 1'b0);
    frame_body(0, 8'hA5, 1'b0, 1'b0, 10, "busy_a5");
    for (int i = 0; i < 2 * CPB; i++) begin
      step();
      check($sformatf("busy idle serial %0d", i), 8'(ser_n), 8'h1);
      check($sformatf("busy idle ready %0d", i), 8'(ready_n), 8'h1);
      check($sformatf("busy idle done %0d", i), 8'(done_n), 8'h0);
    end

    // Reset during data bit 3 (cycles 17..20) of 0xA5.
    accept(0, 8'hA5);
    set_valid(0, 1'b0);
    for (int k = 1; k < 18; k++) step();
    check("mid bit3 serial", 8'(ser_n), 8'h0);
    nRST = 1'b0;
    step();
    check("mid rst serial", 8'(ser_n), 8'h1);
    check("mid rst ready", 8'(ready_n), 8'h1);
    check("mid rst done", 8'(done_n), 8'h0);
    nRST = 1'b1;
    for (int i = 0; i < 2 * CPB; i++) begin
      step();
      check($sformatf("mid idle serial %0d", i), 8'(ser_n), 8'h1);
      check($sformatf("mid idle done %0d", i), 8'(done_n), 8'h0);
    end
    accept(0, 8'h5A);
    set_valid(0, 1'b0);
    frame_body(0, 8'h5A, 1'b0, 1'b0, 0, "n_5a");
    step();
    check("n_5a done clears", 8'(done_n), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
